// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: RAM handshake status, word type, FSM states
// and the index-width helper used by the top level and the picker.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int WORD_W_DEFAULT = 32;
    typedef logic [WORD_W_DEFAULT-1:0] word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // A single channel still needs a one-bit index so the registers stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester channels, RAM port and flush/halt signals of the RAM arbiter.
// master = CPUs plus RAM side (environment), slave = the arbiter itself.
interface ram_arbiter_if #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
);
    import ram_arbiter_pkg::*;

    logic [CPUS-1:0]             dREN;
    logic [CPUS-1:0]             dWEN;
    logic [CPUS-1:0][WORD_W-1:0] daddr;
    logic [CPUS-1:0][WORD_W-1:0] dstore;
    logic [CPUS-1:0]             dwait;
    logic [WORD_W-1:0]           dload;
    logic [CPUS-1:0]             derr;
    logic [CPUS-1:0]             flushed;
    logic                        halt;
    logic [WORD_W-1:0]           ramaddr;
    logic [WORD_W-1:0]           ramstore;
    logic                        ramREN;
    logic                        ramWEN;
    logic [WORD_W-1:0]           ramload;
    ramstate_t                   ramstate;

    modport master (
        output dREN, dWEN, daddr, dstore, flushed, ramload, ramstate,
        input  dwait, dload, derr, halt, ramaddr, ramstore, ramREN, ramWEN
    );

    modport slave (
        input  dREN, dWEN, daddr, dstore, flushed, ramload, ramstate,
        output dwait, dload, derr, halt, ramaddr, ramstore, ramREN, ramWEN
    );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Rotating-priority winner selection: the first requesting index at or after ptr,
// searched modulo N. Tying ptr to zero turns it into lowest-index-wins.
module rr_picker
    import ram_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] index
);
    logic [IW:0]   sum  [N];
    logic [IW-1:0] cand [N];
    logic          hit;

    // cand[k] is the channel examined k-th; ptr is always below N so one subtract wraps it.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign sum[gi]  = {1'b0, ptr} + (IW+1)'(gi);
        assign cand[gi] = (sum[gi] >= (IW+1)'(N)) ? IW'(sum[gi] - (IW+1)'(N))
                                                  : sum[gi][IW-1:0];
    end

    always_comb begin
        index = '0;
        hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!hit && req[j] && (cand[k] == IW'(j))) begin
                    index = IW'(j);
                    hit   = 1'b1;
                end
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/ram_arbiter.sv
// Grants one of CPUS requester channels the single RAM port per transaction,
// fixed priority (MODE 0) or round-robin (MODE 1), plus a sticky all-flushed halt.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int MODE   = 1,
    parameter int WORD_W = 32
) (
    input logic          CLK,
    input logic          RST,
    ram_arbiter_if.slave bus
);
    localparam int IW = idx_w(CPUS);

    arb_state_t        state_reg, state_next;
    logic [IW-1:0]     owner_reg, owner_next;
    logic [IW-1:0]     ptr_reg, ptr_next;
    logic [IW-1:0]     pick_ptr, pick_index, owner_inc;
    logic              pick_valid;
    logic              halt_reg;
    logic [CPUS-1:0]   req, is_owner;
    logic              own_ren, own_wen, own_req;
    logic [WORD_W-1:0] own_addr, own_store;

    assign req      = bus.dREN | bus.dWEN;
    assign pick_ptr = (MODE == 0) ? '0 : ptr_reg;

    rr_picker #(.N(CPUS), .IW(IW)) u_picker (
        .req   (req),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .index (pick_index)
    );

    for (genvar gi = 0; gi < CPUS; gi++) begin : g_owner
        assign is_owner[gi] = (owner_reg == IW'(gi));
    end

    // Live view of the owner's request lines; the owner is never re-sampled mid-transaction.
    always_comb begin
        own_ren   = 1'b0;
        own_wen   = 1'b0;
        own_addr  = '0;
        own_store = '0;
        for (int j = 0; j < CPUS; j++) begin
            if (is_owner[j]) begin
                own_ren   = bus.dREN[j];
                own_wen   = bus.dWEN[j];
                own_addr  = bus.daddr[j];
                own_store = bus.dstore[j];
            end
        end
    end

    assign own_req   = own_ren | own_wen;
    assign owner_inc = (owner_reg == IW'(CPUS - 1)) ? '0 : owner_reg + IW'(1);

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        ptr_next     = ptr_reg;
        bus.dwait    = req;
        bus.derr     = '0;
        bus.dload    = '0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.halt     = halt_reg;

        if (state_reg == IDLE) begin
            if (pick_valid) begin
                state_next = OWNED;
                owner_next = pick_index;
            end
        end else begin
            bus.ramaddr  = own_addr;
            bus.ramstore = own_store;
            bus.ramWEN   = own_wen;
            bus.ramREN   = own_ren & ~own_wen;
            // An abandoned request releases the port without advancing fairness.
            if (!own_req) begin
                state_next = IDLE;
            end else if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
                state_next = IDLE;
                bus.dwait  = req & ~is_owner;
                bus.dload  = bus.ramload;
                if (bus.ramstate == ERROR) begin
                    bus.derr = is_owner;
                end
                if (MODE == 1) begin
                    ptr_next = owner_inc;
                end
            end
        end

        // Outputs are forced quiet for the whole reset window, not just after the edge.
        if (RST) begin
            bus.dwait    = '0;
            bus.derr     = '0;
            bus.dload    = '0;
            bus.ramaddr  = '0;
            bus.ramstore = '0;
            bus.ramREN   = 1'b0;
            bus.ramWEN   = 1'b0;
            bus.halt     = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            ptr_reg   <= '0;
            halt_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            if (&bus.flushed) begin
                halt_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios on four configurations plus a randomized
// run of the 4-channel round-robin arbiter against a transaction-level reference.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.CPUS(2), .WORD_W(32)) if2  ();
    ram_arbiter_if #(.CPUS(4), .WORD_W(32)) if4r ();
    ram_arbiter_if #(.CPUS(4), .WORD_W(32)) if4f ();
    ram_arbiter_if #(.CPUS(1), .WORD_W(32)) if1  ();

    ram_arbiter #(.CPUS(2), .MODE(1), .WORD_W(32)) dut2  (.CLK(clk), .RST(rst), .bus(if2));
    ram_arbiter #(.CPUS(4), .MODE(1), .WORD_W(32)) dut4r (.CLK(clk), .RST(rst), .bus(if4r));
    ram_arbiter #(.CPUS(4), .MODE(0), .WORD_W(32)) dut4f (.CLK(clk), .RST(rst), .bus(if4f));
    ram_arbiter #(.CPUS(1), .MODE(1), .WORD_W(32)) dut1  (.CLK(clk), .RST(rst), .bus(if1));

    task automatic clear_inputs();
        if2.dREN  = '0; if2.dWEN  = '0; if2.daddr  = '0; if2.dstore  = '0;
        if2.flushed  = '0; if2.ramload  = '0; if2.ramstate  = FREE;
        if4r.dREN = '0; if4r.dWEN = '0; if4r.daddr = '0; if4r.dstore = '0;
        if4r.flushed = '0; if4r.ramload = '0; if4r.ramstate = FREE;
        if4f.dREN = '0; if4f.dWEN = '0; if4f.daddr = '0; if4f.dstore = '0;
        if4f.flushed = '0; if4f.ramload = '0; if4f.ramstate = FREE;
        if1.dREN  = '0; if1.dWEN  = '0; if1.daddr  = '0; if1.dstore  = '0;
        if1.flushed  = '0; if1.ramload  = '0; if1.ramstate  = FREE;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        if4r.dREN = 4'b0101; if4r.dWEN = 4'b0010; if4r.daddr[0] = 32'h10;
        if4r.ramstate = ACCESS; if4r.ramload = 32'h1234_5678; if2.flushed = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({if4r.dwait, if4r.derr, if4r.ramREN, if4r.ramWEN} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got dwait=%b derr=%b ren=%b wen=%b want all 0",
                     if4r.dwait, if4r.derr, if4r.ramREN, if4r.ramWEN);
        end
        n_vec++;
        if ({if4r.ramaddr, if4r.ramstore, if4r.dload} !== 96'h0) begin
            n_err++;
            $display("FAIL reset_data got addr=%h store=%h dload=%h want 0",
                     if4r.ramaddr, if4r.ramstore, if4r.dload);
        end
        n_vec++;
        if (if2.halt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_halt got %b want 0", if2.halt);
        end
        if2.flushed = 2'b00;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({if4r.dwait, if4r.ramREN, if4r.ramWEN, if4r.ramaddr} !== {4'b0111, 2'b00, 32'h0}) begin
            n_err++;
            $display("FAIL reset_idle got dwait=%b ren=%b wen=%b addr=%h want dwait=0111 ren=0 wen=0 addr=0",
                     if4r.dwait, if4r.ramREN, if4r.ramWEN, if4r.ramaddr);
        end
    endtask

    task automatic test_two_ch();
        logic [1:0]  e_dwait [4];
        logic        e_ren   [4];
        logic [31:0] e_addr  [4];
        logic [31:0] e_load  [4];
        e_dwait = '{2'b11, 2'b10, 2'b10, 2'b00};
        e_ren   = '{1'b0, 1'b1, 1'b0, 1'b1};
        e_addr  = '{32'h0, 32'h40, 32'h0, 32'h240};
        e_load  = '{32'h0, 32'h1111_0040, 32'h0, 32'h2222_0240};
        do_reset();
        if2.daddr[0] = 32'h40;
        if2.daddr[1] = 32'h240;
        for (int c = 0; c < 4; c++) begin
            if2.dREN     = (c < 2) ? 2'b11 : 2'b10;
            if2.ramstate = (c == 0) ? BUSY : ACCESS;
            if2.ramload  = (c < 2) ? 32'h1111_0040 : 32'h2222_0240;
            #1;
            n_vec++;
            if ({if2.dwait, if2.ramREN, if2.ramaddr, if2.dload} !==
                {e_dwait[c], e_ren[c], e_addr[c], e_load[c]}) begin
                n_err++;
                $display("FAIL two_ch c%0d got dwait=%b ren=%b addr=%h dload=%h want dwait=%b ren=%b addr=%h dload=%h",
                         c, if2.dwait, if2.ramREN, if2.ramaddr, if2.dload,
                         e_dwait[c], e_ren[c], e_addr[c], e_load[c]);
            end
            next_cycle();
        end
        if2.dREN = '0;
    endtask

    task automatic test_rr_fair();
        int         grants[$];
        int         g;
        logic [3:0] exp_w, mask;
        do_reset();
        for (int i = 0; i < 4; i++) if4r.daddr[i] = 32'h100 * i;
        if4r.dREN = 4'hF;
        if4r.ramstate = ACCESS;
        for (int c = 0; c < 20; c++) begin
            #1;
            exp_w = (c % 2 == 0) ? 4'hF : (4'hF & ~(4'b0001 << ((c / 2) % 4)));
            n_vec++;
            if (if4r.dwait !== exp_w) begin
                n_err++;
                $display("FAIL rr_order c%0d got dwait=%b want %b", c, if4r.dwait, exp_w);
            end
            if (c % 2 == 1) begin
                g = -1;
                for (int i = 0; i < 4; i++) if (!if4r.dwait[i]) g = i;
                grants.push_back(g);
            end
            next_cycle();
        end
        for (int w = 0; w + 4 <= grants.size(); w++) begin
            mask = 4'b0;
            for (int k = 0; k < 4; k++) if (grants[w+k] >= 0) mask = mask | (4'b0001 << grants[w+k]);
            n_vec++;
            if (mask !== 4'hF) begin
                n_err++;
                $display("FAIL rr_window w%0d got granted set %b want 1111", w, mask);
            end
        end
        if4r.dREN = '0;
    endtask

    task automatic test_fixed();
        logic [3:0]  exp_w;
        logic [31:0] exp_a;
        do_reset();
        if4f.daddr[1] = 32'h1000;
        if4f.daddr[3] = 32'h3000;
        if4f.dREN = 4'b1010;
        if4f.ramstate = ACCESS;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_w = (c % 2 == 1) ? 4'b1000 : 4'b1010;
            exp_a = (c % 2 == 1) ? 32'h1000 : 32'h0;
            n_vec++;
            if ({if4f.dwait, if4f.ramaddr} !== {exp_w, exp_a}) begin
                n_err++;
                $display("FAIL fixed c%0d got dwait=%b addr=%h want dwait=%b addr=%h",
                         c, if4f.dwait, if4f.ramaddr, exp_w, exp_a);
            end
            next_cycle();
        end
        if4f.dREN = '0;
    endtask

    task automatic test_write_err();
        logic [69:0] got, want;
        logic [69:0] e_tab [4];
        // {dwait, ramWEN, ramREN, ramstore, derr, dload[31:0]} per cycle
        e_tab = '{{2'b10, 1'b0, 1'b0, 32'h0,         2'b00, 32'h0},
                  {2'b10, 1'b1, 1'b0, 32'hDEADBEEF,  2'b00, 32'h0},
                  {2'b00, 1'b1, 1'b0, 32'hDEADBEEF,  2'b10, 32'hCAFE0001},
                  {2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 32'h0}};
        do_reset();
        if2.daddr[1] = 32'h80;
        if2.dstore[1] = 32'hDEADBEEF;
        if2.ramload = 32'hCAFE0001;
        for (int c = 0; c < 4; c++) begin
            if2.dREN = (c < 3) ? 2'b10 : 2'b00;
            if2.dWEN = (c < 3) ? 2'b10 : 2'b00;
            if2.ramstate = (c < 2) ? BUSY : ERROR;
            #1;
            got  = {if2.dwait, if2.ramWEN, if2.ramREN, if2.ramstore, if2.derr, if2.dload};
            want = e_tab[c];
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL write_err c%0d got {dwait,wen,ren,store,derr,dload}=%h want %h", c, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_drop();
        logic [40:0] got;
        logic [40:0] e_tab [7];
        // {dwait, ramREN, ramaddr, derr} per cycle
        e_tab = '{{4'b0100, 1'b0, 32'h0,   4'b0},
                  {4'b0000, 1'b1, 32'h200, 4'b0},
                  {4'b0010, 1'b0, 32'h0,   4'b0},
                  {4'b0010, 1'b1, 32'h100, 4'b0},
                  {4'b0101, 1'b0, 32'h100, 4'b0},
                  {4'b0101, 1'b0, 32'h0,   4'b0},
                  {4'b0100, 1'b1, 32'h0C0, 4'b0}};
        do_reset();
        if4r.daddr[0] = 32'h0C0;
        if4r.daddr[1] = 32'h100;
        if4r.daddr[2] = 32'h200;
        for (int c = 0; c < 7; c++) begin
            case (c)
                0, 1:    if4r.dREN = 4'b0100;
                2, 3:    if4r.dREN = 4'b0010;
                default: if4r.dREN = 4'b0101;
            endcase
            if4r.ramstate = (c < 2 || c > 4) ? ACCESS : BUSY;
            #1;
            got = {if4r.dwait, if4r.ramREN, if4r.ramaddr, if4r.derr};
            n_vec++;
            if (got !== e_tab[c]) begin
                n_err++;
                $display("FAIL drop c%0d got {dwait,ren,addr,derr}=%h want %h", c, got, e_tab[c]);
            end
            next_cycle();
        end
        if4r.dREN = '0;
    endtask

    task automatic test_cpus1();
        do_reset();
        if1.daddr[0] = 32'h55;
        if1.dREN = 1'b1;
        if1.ramstate = ACCESS;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_vec++;
            if ({if1.dwait, if1.ramREN} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL cpus1 c%0d got dwait=%b ren=%b want dwait=%b ren=%b",
                         c, if1.dwait, if1.ramREN, (c % 2 == 0), (c % 2 == 1));
            end
            next_cycle();
        end
        if1.dREN = '0;
    endtask

    // Reference: idle grants scan from ptr modulo 4; an owner keeps the port until
    // its ACCESS/ERROR cycle (ptr advances past it) or until it abandons the request.
    task automatic test_random();
        bit          pend [4], rd [4], wr [4], rel [4];
        logic [31:0] ad [4], dt [4];
        int          m_owner, m_ptr, nxt_owner, r, cc;
        logic [3:0]  req, e_dwait, e_derr;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store, e_load, load;
        logic [105:0] got, want;
        ramstate_t   rs;
        do_reset();
        m_owner = -1;
        m_ptr   = 0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 0; rd[i] = 0; wr[i] = 0; rel[i] = 0; ad[i] = '0; dt[i] = '0;
        end
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && (rel[i] || $urandom_range(0, 19) == 0)) begin
                    pend[i] = 0;
                end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    r = $urandom_range(0, 2);
                    rd[i] = (r != 1);
                    wr[i] = (r != 0);
                    ad[i] = $urandom;
                    dt[i] = $urandom;
                end
                if4r.dREN[i]   = pend[i] & rd[i];
                if4r.dWEN[i]   = pend[i] & wr[i];
                if4r.daddr[i]  = ad[i];
                if4r.dstore[i] = dt[i];
                req[i] = pend[i];
                rel[i] = 0;
            end
            r  = $urandom_range(0, 9);
            rs = (r < 4) ? BUSY : (r == 4) ? FREE : (r < 9) ? ACCESS : ERROR;
            load = $urandom;
            if4r.ramstate = rs;
            if4r.ramload  = load;

            e_dwait = req; e_derr = '0; e_ren = 0; e_wen = 0;
            e_addr = '0; e_store = '0; e_load = '0;
            nxt_owner = m_owner;
            if (m_owner < 0) begin
                for (int k = 3; k >= 0; k--) begin
                    cc = (m_ptr + k) % 4;
                    if (req[cc]) nxt_owner = cc;
                end
            end else begin
                e_addr  = ad[m_owner];
                e_store = dt[m_owner];
                e_wen   = pend[m_owner] && wr[m_owner];
                e_ren   = pend[m_owner] && rd[m_owner] && !wr[m_owner];
                if (!req[m_owner]) begin
                    nxt_owner = -1;
                end else if (rs == ACCESS || rs == ERROR) begin
                    e_dwait[m_owner] = 1'b0;
                    e_load = load;
                    if (rs == ERROR) e_derr[m_owner] = 1'b1;
                    rel[m_owner] = 1;
                    m_ptr = (m_owner + 1) % 4;
                    nxt_owner = -1;
                end
            end
            #1;
            got  = {if4r.dwait, if4r.derr, if4r.ramREN, if4r.ramWEN, if4r.ramaddr, if4r.ramstore, if4r.dload};
            want = {e_dwait, e_derr, e_ren, e_wen, e_addr, e_store, e_load};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL random c%0d got {dwait,derr,ren,wen,addr,store,dload}=%h want %h", c, got, want);
            end
            next_cycle();
            m_owner = nxt_owner;
        end
        if4r.dREN = '0;
        if4r.dWEN = '0;
    endtask

    task automatic test_halt();
        do_reset();
        if2.flushed = 2'b01;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if (if2.halt !== 1'b0) begin
                n_err++;
                $display("FAIL halt_partial c%0d got %b want 0", c, if2.halt);
            end
            next_cycle();
        end
        if2.flushed = 2'b11;
        #1;
        n_vec++;
        if (if2.halt !== 1'b0) begin
            n_err++;
            $display("FAIL halt_same_cycle got %b want 0", if2.halt);
        end
        next_cycle();
        if2.flushed = 2'b00;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if (if2.halt !== 1'b1) begin
                n_err++;
                $display("FAIL halt_sticky c%0d got %b want 1", c, if2.halt);
            end
            next_cycle();
        end
        if2.daddr[0] = 32'h44;
        if2.dREN = 2'b01;
        if2.ramstate = BUSY;
        next_cycle();
        #1;
        n_vec++;
        if (if2.ramREN !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre got ramREN=%b want 1", if2.ramREN);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({if2.ramREN, if2.halt, if2.dwait} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_async got ren=%b halt=%b dwait=%b want 0 0 00",
                     if2.ramREN, if2.halt, if2.dwait);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({if2.ramREN, if2.halt, if2.dwait} !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_discard got ren=%b halt=%b dwait=%b want 0 0 01",
                     if2.ramREN, if2.halt, if2.dwait);
        end
        if2.dREN = '0;
    endtask

    initial begin
        test_reset();
        test_two_ch();
        test_rr_fair();
        test_fixed();
        test_write_err();
        test_drop();
        test_cpus1();
        test_random();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
